// File: rtl/det_pkg.sv
// Shared constants and types for the determinant stream collector.
package det_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int WINDOW_DEF = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int sum_w(input int data_w, input int window);
        return data_w + $clog2(window);
    endfunction

endpackage

// File: rtl/det_stat_update.sv
// Combinational next-statistics step: folds one sample into sum/max/min/count.
module det_stat_update
    import det_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 3,
    parameter int SUM_W  = 10
) (
    input  logic signed [SUM_W-1:0]  sum,
    input  logic signed [DATA_W-1:0] max_v,
    input  logic signed [DATA_W-1:0] min_v,
    input  logic [CNT_W-1:0]         cnt,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     first,
    output logic signed [SUM_W-1:0]  nxt_sum,
    output logic signed [DATA_W-1:0] nxt_max,
    output logic signed [DATA_W-1:0] nxt_min,
    output logic [CNT_W-1:0]         nxt_cnt
);

    logic signed [SUM_W-1:0] ext;

    assign ext = SUM_W'(din);

    always_comb begin
        nxt_sum = ext;
        nxt_max = din;
        nxt_min = din;
        nxt_cnt = CNT_W'(1);
        if (!first) begin
            nxt_sum = sum + ext;
            nxt_max = (din > max_v) ? din : max_v;
            nxt_min = (din < min_v) ? din : min_v;
            nxt_cnt = cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/det_stream_collector.sv
// Windowed sum/max/min collector for determinant results.
// Optional zero-sample counter enabled by DET_COLLECT_ZERO_CNT_EN.
module det_stream_collector
    import det_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WINDOW = WINDOW_DEF,
    parameter int CNT_W  = $clog2(WINDOW + 1),
    parameter int SUM_W  = sum_w(DATA_W, WINDOW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [CNT_W-1:0]  out_cnt
`ifdef DET_COLLECT_ZERO_CNT_EN
    ,
    output logic [CNT_W-1:0]  out_zero_cnt
`endif
);

    state_t state, state_n;

    logic [CNT_W-1:0]         cnt;
    logic signed [SUM_W-1:0]  acc_sum;
    logic signed [DATA_W-1:0] acc_max, acc_min;

    logic [CNT_W-1:0]         nxt_cnt;
    logic signed [SUM_W-1:0]  nxt_sum;
    logic signed [DATA_W-1:0] nxt_max, nxt_min;
    logic signed [DATA_W-1:0] din;

    logic accept, first, close;

    assign din       = in_data;
    assign in_ready  = (state == ACCUM) && !reset;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign first     = (cnt == '0);

    det_stat_update #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .SUM_W  (SUM_W)
    ) u_stat (
        .sum     (acc_sum),
        .max_v   (acc_max),
        .min_v   (acc_min),
        .cnt     (cnt),
        .din     (din),
        .first   (first),
        .nxt_sum (nxt_sum),
        .nxt_max (nxt_max),
        .nxt_min (nxt_min),
        .nxt_cnt (nxt_cnt)
    );

    // A flush closes the window only if it holds at least one sample.
    assign close = (state == ACCUM) && !reset &&
                   ((accept && nxt_cnt == CNT_W'(WINDOW)) ||
                    (flush && (!first || accept)));

    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ACCUM: if (close) state_n = HOLD;
            HOLD:  if (out_ready) state_n = ACCUM;
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            acc_sum <= '0;
            acc_max <= '0;
            acc_min <= '0;
            out_sum <= '0;
            out_max <= '0;
            out_min <= '0;
            out_cnt <= '0;
        end else if (close) begin
            out_sum <= accept ? nxt_sum : acc_sum;
            out_max <= accept ? nxt_max : acc_max;
            out_min <= accept ? nxt_min : acc_min;
            out_cnt <= accept ? nxt_cnt : cnt;
            cnt     <= '0;
            acc_sum <= '0;
            acc_max <= '0;
            acc_min <= '0;
        end else if (accept) begin
            cnt     <= nxt_cnt;
            acc_sum <= nxt_sum;
            acc_max <= nxt_max;
            acc_min <= nxt_min;
        end
    end

`ifdef DET_COLLECT_ZERO_CNT_EN
    logic [CNT_W-1:0] zc, zc_n;

    assign zc_n = zc + CNT_W'(accept && (in_data == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            zc           <= '0;
            out_zero_cnt <= '0;
        end else if (close) begin
            out_zero_cnt <= zc_n;
            zc           <= '0;
        end else begin
            zc <= zc_n;
        end
    end
`endif

endmodule

// File: tb/tb_det_stream_collector.sv
// Self-checking bench: directed scenarios plus random stream vs. a queue model.
module tb_det_stream_collector;

    localparam int DATA_W = 8;
    localparam int WINDOW = 4;
    localparam int CNT_W  = 3;
    localparam int SUM_W  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_max;
    logic [DATA_W-1:0] out_min;
    logic [CNT_W-1:0]  out_cnt;
`ifdef DET_COLLECT_ZERO_CNT_EN
    logic [CNT_W-1:0]  out_zero_cnt;
`endif

    det_stream_collector #(
        .DATA_W (DATA_W),
        .WINDOW (WINDOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_max   (out_max),
        .out_min   (out_min),
        .out_cnt   (out_cnt)
`ifdef DET_COLLECT_ZERO_CNT_EN
        ,
        .out_zero_cnt (out_zero_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int win[$];
    bit m_hold;
    int m_sum, m_max, m_min, m_cnt, m_zc;

    task automatic chk(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic close_window();
        m_sum = 0;
        m_zc  = 0;
        m_max = win[0];
        m_min = win[0];
        foreach (win[i]) begin
            m_sum += win[i];
            if (win[i] > m_max) m_max = win[i];
            if (win[i] < m_min) m_min = win[i];
            if (win[i] == 0) m_zc++;
        end
        m_cnt  = win.size();
        m_hold = 1'b1;
        win.delete();
    endtask

    task automatic cyc(input bit v, input int d, input bit fl,
                       input bit ordy, input bit rst);
        integer s, mx, mn;
        bit acc;
        in_valid  = v;
        in_data   = DATA_W'(d);
        flush     = fl;
        out_ready = ordy;
        reset     = rst;
        #1;
        s  = $signed(out_sum);
        mx = $signed(out_max);
        mn = $signed(out_min);
        chk("in_ready", in_ready, (!m_hold && !rst));
        chk("out_valid", out_valid, m_hold);
        chk("out_sum", s, m_sum);
        chk("out_max", mx, m_max);
        chk("out_min", mn, m_min);
        chk("out_cnt", out_cnt, m_cnt);
`ifdef DET_COLLECT_ZERO_CNT_EN
        chk("out_zero_cnt", out_zero_cnt, m_zc);
`endif
        if (rst) begin
            win.delete();
            m_hold = 1'b0;
            m_sum = 0; m_max = 0; m_min = 0; m_cnt = 0; m_zc = 0;
        end else if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else begin
            acc = v;
            if (acc) win.push_back(int'($signed(DATA_W'(d))));
            if ((acc && win.size() == WINDOW) || (fl && win.size() > 0))
                close_window();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input int s, input int mx,
                       input int mn, input int c);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_rdy"}, in_ready, 0);
        chk({tag, "_sum"}, $signed(out_sum), s);
        chk({tag, "_max"}, $signed(out_max), mx);
        chk({tag, "_min"}, $signed(out_min), mn);
        chk({tag, "_cnt"}, out_cnt, c);
    endtask

    initial begin
        in_valid = 0; in_data = '0; flush = 0; out_ready = 0; reset = 1;
        repeat (2) @(posedge clk);
        #1;
        m_hold = 0; m_sum = 0; m_max = 0; m_min = 0; m_cnt = 0; m_zc = 0;
        cyc(0, 0, 0, 0, 1);
        cyc(1, 5, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        // leftover sample 5 was flushed into a summary; drain it
        cyc(0, 0, 0, 1, 0);

        // Back-to-back window
        cyc(1, 3, 0, 1, 0);
        cyc(1, -5, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 7, 0, 1, 0);
        lit("tp1", 5, 7, -5, 4);
`ifdef DET_COLLECT_ZERO_CNT_EN
        chk("tp1_zc", out_zero_cnt, 1);
`endif
        cyc(0, 0, 0, 1, 0);
        chk("tp1_rdy_back", in_ready, 1);

        // Stalled downstream
        cyc(1, 3, 0, 0, 0);
        cyc(1, -5, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 7, 0, 0, 0);
        cyc(1, 9, 1, 0, 0);
        cyc(1, 9, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        lit("tp2", 5, 7, -5, 4);
        cyc(0, 0, 0, 1, 0);
        chk("tp2_rdy_back", in_ready, 1);

        // Flush alone, then empty flush
        cyc(1, 10, 0, 1, 0);
        cyc(1, 20, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        lit("tp3", 30, 20, 10, 2);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        chk("tp3_noflush", out_valid, 0);
        cyc(0, 0, 0, 1, 0);

        // Extremes
        repeat (4) cyc(1, -128, 0, 1, 0);
        lit("tp4n", -512, -128, -128, 4);
        cyc(0, 0, 0, 1, 0);
        repeat (4) cyc(1, 127, 0, 1, 0);
        lit("tp4p", 508, 127, 127, 4);
        cyc(0, 0, 0, 1, 0);

        // Reset mid-window
        cyc(1, 9, 0, 1, 0);
        cyc(1, 9, 0, 1, 0);
        cyc(1, 9, 0, 1, 1);
        repeat (4) cyc(1, 1, 0, 1, 0);
        lit("tp5", 4, 1, 1, 4);
        cyc(0, 0, 0, 1, 0);

        // Flush with the third accept
        cyc(1, 1, 0, 1, 0);
        cyc(1, 2, 0, 1, 0);
        cyc(1, 3, 1, 1, 0);
        lit("tp6", 6, 3, 1, 3);
        cyc(0, 0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 9) < 7,
                ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
